// File: rtl/rs_disorder_pkg.sv
// Shared widths and CDB snoop helpers for the out-of-order reservation station.
package rs_disorder_pkg;

  localparam int DP_NUM_WIDTH = 2;
  localparam int DATA_LEN     = 32;
  localparam int RRF_SEL      = 6;

  typedef struct packed {
    logic                vld;
    logic [RRF_SEL-1:0]  tag;
    logic [DATA_LEN-1:0] val;
  } cdb_t;

  function automatic logic cdb_hit(input cdb_t cdb, input logic [RRF_SEL-1:0] tag);
    return cdb.vld && (cdb.tag == tag);
  endfunction

endpackage

// File: rtl/alloc_issue_disorder.sv
// Free-entry allocator (two lowest free slots) and fixed-priority issue picker (lowest ready).
module alloc_issue_disorder
  import rs_disorder_pkg::*;
#(
  parameter int ENT_NUM = 4,
  parameter int ENT_SEL = 2
) (
  input  logic [ENT_NUM-1:0]      i_busy_vec,
  input  logic [DP_NUM_WIDTH-1:0] i_req_num,
  output logic [ENT_SEL-1:0]      o_alloc_sel_1,
  output logic [ENT_SEL-1:0]      o_alloc_sel_2,
  output logic                    o_alloc_vld_1,
  output logic                    o_alloc_vld_2,
  output logic                    o_allocable,
  input  logic [ENT_NUM-1:0]      i_vld_vec,
  output logic [ENT_SEL-1:0]      o_issue_sel,
  output logic                    o_issue_vld
);

  int unsigned free_cnt;

  always_comb begin
    o_alloc_sel_1 = '0;
    o_alloc_sel_2 = '0;
    o_alloc_vld_1 = 1'b0;
    o_alloc_vld_2 = 1'b0;
    o_issue_sel   = '0;
    o_issue_vld   = 1'b0;
    free_cnt      = 0;
    for (int unsigned i = 0; i < ENT_NUM; i++) begin
      if (!i_busy_vec[i]) begin
        free_cnt = free_cnt + 1;
        if (!o_alloc_vld_1) begin
          o_alloc_sel_1 = ENT_SEL'(i);
          o_alloc_vld_1 = 1'b1;
        end else if (!o_alloc_vld_2) begin
          o_alloc_sel_2 = ENT_SEL'(i);
          o_alloc_vld_2 = 1'b1;
        end
      end
      if (i_vld_vec[i] && !o_issue_vld) begin
        o_issue_sel = ENT_SEL'(i);
        o_issue_vld = 1'b1;
      end
    end
    o_allocable = (free_cnt >= 32'(i_req_num));
  end

endmodule

// File: rtl/rs_src_capture.sv
// One source operand of one RS entry: dispatch write with same-cycle CDB bypass, then wakeup.
module rs_src_capture
  import rs_disorder_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_wr,
  input  logic [DATA_LEN-1:0] i_val,
  input  logic [RRF_SEL-1:0]  i_tag,
  input  logic                i_rdy,
  input  logic                i_busy,
  input  cdb_t                i_cdb_1,
  input  cdb_t                i_cdb_2,
  output logic [DATA_LEN-1:0] o_val,
  output logic                o_rdy
);

  logic [DATA_LEN-1:0] val_q, val_d;
  logic [RRF_SEL-1:0]  tag_q, tag_d;
  logic                rdy_q, rdy_d;

  always_comb begin
    val_d = val_q;
    tag_d = tag_q;
    rdy_d = rdy_q;
    if (i_wr) begin
      tag_d = i_tag;
      if (i_rdy) begin
        val_d = i_val;
        rdy_d = 1'b1;
      end else if (cdb_hit(i_cdb_1, i_tag)) begin
        val_d = i_cdb_1.val;
        rdy_d = 1'b1;
      end else if (cdb_hit(i_cdb_2, i_tag)) begin
        val_d = i_cdb_2.val;
        rdy_d = 1'b1;
      end else begin
        rdy_d = 1'b0;
      end
    end else if (i_busy && !rdy_q) begin
      if (cdb_hit(i_cdb_1, tag_q)) begin
        val_d = i_cdb_1.val;
        rdy_d = 1'b1;
      end else if (cdb_hit(i_cdb_2, tag_q)) begin
        val_d = i_cdb_2.val;
        rdy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rdy_q <= 1'b0;
    else          rdy_q <= rdy_d;
  end

  always_ff @(posedge i_clk) begin
    val_q <= val_d;
    tag_q <= tag_d;
  end

  assign o_val = val_q;
  assign o_rdy = rdy_q;

endmodule

// File: rtl/rs_disorder.sv
// Out-of-order reservation station: dual dispatch, dual-CDB wakeup, single issue per cycle.
module rs_disorder
  import rs_disorder_pkg::*;
#(
  parameter int ENT_NUM = 4,
  parameter int ENT_SEL = 2,
  parameter int OP_W    = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_flush,
  input  logic [DP_NUM_WIDTH-1:0] i_dp_num,
  input  logic                    i_dp_vld_1,
  input  logic                    i_dp_vld_2,
  input  logic [OP_W-1:0]         i_dp_op_1,
  input  logic [OP_W-1:0]         i_dp_op_2,
  input  logic [DATA_LEN-1:0]     i_dp_s1_val_1,
  input  logic [DATA_LEN-1:0]     i_dp_s1_val_2,
  input  logic [DATA_LEN-1:0]     i_dp_s2_val_1,
  input  logic [DATA_LEN-1:0]     i_dp_s2_val_2,
  input  logic [RRF_SEL-1:0]      i_dp_s1_tag_1,
  input  logic [RRF_SEL-1:0]      i_dp_s1_tag_2,
  input  logic [RRF_SEL-1:0]      i_dp_s2_tag_1,
  input  logic [RRF_SEL-1:0]      i_dp_s2_tag_2,
  input  logic                    i_dp_s1_rdy_1,
  input  logic                    i_dp_s1_rdy_2,
  input  logic                    i_dp_s2_rdy_1,
  input  logic                    i_dp_s2_rdy_2,
  input  logic [RRF_SEL-1:0]      i_dp_dst_1,
  input  logic [RRF_SEL-1:0]      i_dp_dst_2,
  output logic                    o_stall,
  input  logic                    i_cdb_vld_1,
  input  logic                    i_cdb_vld_2,
  input  logic [RRF_SEL-1:0]      i_cdb_tag_1,
  input  logic [RRF_SEL-1:0]      i_cdb_tag_2,
  input  logic [DATA_LEN-1:0]     i_cdb_val_1,
  input  logic [DATA_LEN-1:0]     i_cdb_val_2,
  output logic                    o_issue_vld,
  input  logic                    i_issue_rdy,
  output logic [OP_W-1:0]         o_issue_op,
  output logic [DATA_LEN-1:0]     o_issue_s1,
  output logic [DATA_LEN-1:0]     o_issue_s2,
  output logic [RRF_SEL-1:0]      o_issue_dst
);

  logic [ENT_NUM-1:0]  busy_q, busy_d;
  logic [ENT_NUM-1:0]  ready_vec, wr1_vec, wr2_vec, wr_vec;
  logic [ENT_NUM-1:0]  s1_rdy, s2_rdy;
  logic [OP_W-1:0]     op_q  [ENT_NUM];
  logic [RRF_SEL-1:0]  dst_q [ENT_NUM];
  logic [DATA_LEN-1:0] s1_val [ENT_NUM];
  logic [DATA_LEN-1:0] s2_val [ENT_NUM];
  logic [ENT_SEL-1:0]  alloc_sel_1, alloc_sel_2, issue_sel;
  logic                alloc_vld_1, alloc_vld_2, allocable, issue_sel_vld;
  logic                we_1, we_2, fire;
  cdb_t                cdb_1, cdb_2;

  assign cdb_1 = '{vld: i_cdb_vld_1, tag: i_cdb_tag_1, val: i_cdb_val_1};
  assign cdb_2 = '{vld: i_cdb_vld_2, tag: i_cdb_tag_2, val: i_cdb_val_2};

  alloc_issue_disorder #(
    .ENT_NUM (ENT_NUM),
    .ENT_SEL (ENT_SEL)
  ) u_sel (
    .i_busy_vec    (busy_q),
    .i_req_num     (i_dp_num),
    .o_alloc_sel_1 (alloc_sel_1),
    .o_alloc_sel_2 (alloc_sel_2),
    .o_alloc_vld_1 (alloc_vld_1),
    .o_alloc_vld_2 (alloc_vld_2),
    .o_allocable   (allocable),
    .i_vld_vec     (ready_vec),
    .o_issue_sel   (issue_sel),
    .o_issue_vld   (issue_sel_vld)
  );

  assign o_stall   = ~allocable;
  assign we_1      = allocable & i_dp_vld_1 & alloc_vld_1;
  assign we_2      = allocable & i_dp_vld_2 & alloc_vld_2;
  assign ready_vec = busy_q & s1_rdy & s2_rdy;
  assign wr_vec    = wr1_vec | wr2_vec;
  assign fire      = issue_sel_vld & i_issue_rdy;

  always_comb begin
    wr1_vec = '0;
    wr2_vec = '0;
    for (int unsigned i = 0; i < ENT_NUM; i++) begin
      wr1_vec[i] = we_1 && (alloc_sel_1 == ENT_SEL'(i));
      wr2_vec[i] = we_2 && (alloc_sel_2 == ENT_SEL'(i));
    end
  end

  // Allocation only picks entries idle before the edge, so a write never hits the issued entry.
  always_comb begin
    busy_d = busy_q;
    if (fire) busy_d[issue_sel] = 1'b0;
    busy_d = busy_d | wr_vec;
    if (i_flush) busy_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  always_ff @(posedge i_clk) begin
    for (int unsigned i = 0; i < ENT_NUM; i++) begin
      if (wr1_vec[i]) begin
        op_q[i]  <= i_dp_op_1;
        dst_q[i] <= i_dp_dst_1;
      end else if (wr2_vec[i]) begin
        op_q[i]  <= i_dp_op_2;
        dst_q[i] <= i_dp_dst_2;
      end
    end
  end

  for (genvar g = 0; g < ENT_NUM; g++) begin : g_ent
    rs_src_capture u_s1 (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_wr    (wr_vec[g]),
      .i_val   (wr2_vec[g] ? i_dp_s1_val_2 : i_dp_s1_val_1),
      .i_tag   (wr2_vec[g] ? i_dp_s1_tag_2 : i_dp_s1_tag_1),
      .i_rdy   (wr2_vec[g] ? i_dp_s1_rdy_2 : i_dp_s1_rdy_1),
      .i_busy  (busy_q[g]),
      .i_cdb_1 (cdb_1),
      .i_cdb_2 (cdb_2),
      .o_val   (s1_val[g]),
      .o_rdy   (s1_rdy[g])
    );
    rs_src_capture u_s2 (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_wr    (wr_vec[g]),
      .i_val   (wr2_vec[g] ? i_dp_s2_val_2 : i_dp_s2_val_1),
      .i_tag   (wr2_vec[g] ? i_dp_s2_tag_2 : i_dp_s2_tag_1),
      .i_rdy   (wr2_vec[g] ? i_dp_s2_rdy_2 : i_dp_s2_rdy_1),
      .i_busy  (busy_q[g]),
      .i_cdb_1 (cdb_1),
      .i_cdb_2 (cdb_2),
      .o_val   (s2_val[g]),
      .o_rdy   (s2_rdy[g])
    );
  end

  assign o_issue_vld = issue_sel_vld;
  assign o_issue_op  = op_q[issue_sel];
  assign o_issue_s1  = s1_val[issue_sel];
  assign o_issue_s2  = s2_val[issue_sel];
  assign o_issue_dst = dst_q[issue_sel];

endmodule

// File: tb/tb_rs_disorder.sv
// Directed bench for rs_disorder: per-cycle vector table plus hand sequences for hold and reset.
module tb_rs_disorder;
  import rs_disorder_pkg::*;

  localparam int ENT_NUM = 4;
  localparam int ENT_SEL = 2;
  localparam int OP_W    = 8;

  logic                    i_clk = 1'b0;
  logic                    i_rst_n, i_flush;
  logic [DP_NUM_WIDTH-1:0] i_dp_num;
  logic                    i_dp_vld_1, i_dp_vld_2;
  logic [OP_W-1:0]         i_dp_op_1, i_dp_op_2;
  logic [DATA_LEN-1:0]     i_dp_s1_val_1, i_dp_s1_val_2, i_dp_s2_val_1, i_dp_s2_val_2;
  logic [RRF_SEL-1:0]      i_dp_s1_tag_1, i_dp_s1_tag_2, i_dp_s2_tag_1, i_dp_s2_tag_2;
  logic                    i_dp_s1_rdy_1, i_dp_s1_rdy_2, i_dp_s2_rdy_1, i_dp_s2_rdy_2;
  logic [RRF_SEL-1:0]      i_dp_dst_1, i_dp_dst_2;
  logic                    o_stall;
  logic                    i_cdb_vld_1, i_cdb_vld_2;
  logic [RRF_SEL-1:0]      i_cdb_tag_1, i_cdb_tag_2;
  logic [DATA_LEN-1:0]     i_cdb_val_1, i_cdb_val_2;
  logic                    o_issue_vld, i_issue_rdy;
  logic [OP_W-1:0]         o_issue_op;
  logic [DATA_LEN-1:0]     o_issue_s1, o_issue_s2;
  logic [RRF_SEL-1:0]      o_issue_dst;

  always #5 i_clk = ~i_clk;

  rs_disorder #(
    .ENT_NUM (ENT_NUM),
    .ENT_SEL (ENT_SEL),
    .OP_W    (OP_W)
  ) dut (
    .i_clk (i_clk), .i_rst_n (i_rst_n), .i_flush (i_flush), .i_dp_num (i_dp_num),
    .i_dp_vld_1 (i_dp_vld_1), .i_dp_vld_2 (i_dp_vld_2),
    .i_dp_op_1 (i_dp_op_1), .i_dp_op_2 (i_dp_op_2),
    .i_dp_s1_val_1 (i_dp_s1_val_1), .i_dp_s1_val_2 (i_dp_s1_val_2),
    .i_dp_s2_val_1 (i_dp_s2_val_1), .i_dp_s2_val_2 (i_dp_s2_val_2),
    .i_dp_s1_tag_1 (i_dp_s1_tag_1), .i_dp_s1_tag_2 (i_dp_s1_tag_2),
    .i_dp_s2_tag_1 (i_dp_s2_tag_1), .i_dp_s2_tag_2 (i_dp_s2_tag_2),
    .i_dp_s1_rdy_1 (i_dp_s1_rdy_1), .i_dp_s1_rdy_2 (i_dp_s1_rdy_2),
    .i_dp_s2_rdy_1 (i_dp_s2_rdy_1), .i_dp_s2_rdy_2 (i_dp_s2_rdy_2),
    .i_dp_dst_1 (i_dp_dst_1), .i_dp_dst_2 (i_dp_dst_2),
    .o_stall (o_stall),
    .i_cdb_vld_1 (i_cdb_vld_1), .i_cdb_vld_2 (i_cdb_vld_2),
    .i_cdb_tag_1 (i_cdb_tag_1), .i_cdb_tag_2 (i_cdb_tag_2),
    .i_cdb_val_1 (i_cdb_val_1), .i_cdb_val_2 (i_cdb_val_2),
    .o_issue_vld (o_issue_vld), .i_issue_rdy (i_issue_rdy),
    .o_issue_op (o_issue_op), .o_issue_s1 (o_issue_s1), .o_issue_s2 (o_issue_s2),
    .o_issue_dst (o_issue_dst)
  );

  // One record per clock cycle. Slot k s2 is always ready with value = op, dst = op[5:0].
  typedef struct {
    logic        flush;
    logic [1:0]  num;
    logic [7:0]  op1, op2;
    logic        r1, r2;
    logic [5:0]  stag;
    logic [31:0] sval;
    logic        c1v;
    logic [5:0]  c1t;
    logic [31:0] c1val;
    logic        c2v;
    logic [5:0]  c2t;
    logic [31:0] c2val;
    logic        irdy;
    logic        e_stall, e_vld;
    logic [7:0]  e_op;
    logic [31:0] e_s1;
  } vec_t;

  vec_t tbl[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t V(input logic fl, input logic [1:0] num, input logic [7:0] op1, op2,
                             input logic r1, r2, input logic [5:0] stag, input logic [31:0] sval,
                             input logic c1v, input logic [5:0] c1t, input logic [31:0] c1val,
                             input logic c2v, input logic [5:0] c2t, input logic [31:0] c2val,
                             input logic irdy, input logic es, ev, input logic [7:0] eop,
                             input logic [31:0] es1);
    vec_t v;
    v.flush = fl; v.num = num; v.op1 = op1; v.op2 = op2; v.r1 = r1; v.r2 = r2;
    v.stag = stag; v.sval = sval; v.c1v = c1v; v.c1t = c1t; v.c1val = c1val;
    v.c2v = c2v; v.c2t = c2t; v.c2val = c2val; v.irdy = irdy;
    v.e_stall = es; v.e_vld = ev; v.e_op = eop; v.e_s1 = es1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    i_flush       = v.flush;
    i_dp_num      = v.num;
    i_dp_vld_1    = (v.num >= 2'd1);
    i_dp_vld_2    = (v.num >= 2'd2);
    i_dp_op_1     = v.op1;
    i_dp_op_2     = v.op2;
    i_dp_s1_val_1 = v.sval;
    i_dp_s1_val_2 = v.sval;
    i_dp_s2_val_1 = 32'(v.op1);
    i_dp_s2_val_2 = 32'(v.op2);
    i_dp_s1_tag_1 = v.stag;
    i_dp_s1_tag_2 = v.stag;
    i_dp_s2_tag_1 = '0;
    i_dp_s2_tag_2 = '0;
    i_dp_s1_rdy_1 = v.r1;
    i_dp_s1_rdy_2 = v.r2;
    i_dp_s2_rdy_1 = 1'b1;
    i_dp_s2_rdy_2 = 1'b1;
    i_dp_dst_1    = v.op1[5:0];
    i_dp_dst_2    = v.op2[5:0];
    i_cdb_vld_1   = v.c1v;
    i_cdb_tag_1   = v.c1t;
    i_cdb_val_1   = v.c1val;
    i_cdb_vld_2   = v.c2v;
    i_cdb_tag_2   = v.c2t;
    i_cdb_val_2   = v.c2val;
    i_issue_rdy   = v.irdy;
  endtask

  // Drive at posedge+1, check at negedge, then advance through the next posedge.
  task automatic step(input vec_t v, input string nm);
    drive(v);
    @(negedge i_clk);
    chk({nm, " stall"}, 32'(o_stall), 32'(v.e_stall));
    chk({nm, " issue_vld"}, 32'(o_issue_vld), 32'(v.e_vld));
    if (v.e_vld) begin
      chk({nm, " issue_op"}, 32'(o_issue_op), 32'(v.e_op));
      chk({nm, " issue_s1"}, o_issue_s1, v.e_s1);
      chk({nm, " issue_s2"}, o_issue_s2, 32'(v.e_op));
      chk({nm, " issue_dst"}, 32'(o_issue_dst), 32'(v.e_op[5:0]));
    end
    @(posedge i_clk);
    #1;
  endtask

  function automatic vec_t IDLE(input logic irdy, input logic ev, input logic [7:0] eop,
                                input logic [31:0] es1);
    return V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, irdy, 0, ev, eop, es1);
  endfunction

  initial begin
    // Two ready ops, issued back to back
    tbl.push_back(V(0, 2, 8'h10, 8'h11, 1, 1, 0, 32'h21, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(IDLE(1, 1, 8'h10, 32'h21));
    tbl.push_back(IDLE(1, 1, 8'h11, 32'h21));
    tbl.push_back(IDLE(1, 0, 0, 0));
    // Fill all four waiting on tag 5, fifth dispatch stalls, CDB wakes all
    tbl.push_back(V(0, 2, 8'h20, 8'h21, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(V(0, 2, 8'h22, 8'h23, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(V(0, 1, 8'h24, 0, 1, 0, 0, 32'h77, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'hAA, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(IDLE(1, 1, 8'h20, 32'hAA));
    tbl.push_back(IDLE(1, 1, 8'h21, 32'hAA));
    tbl.push_back(IDLE(1, 1, 8'h22, 32'hAA));
    tbl.push_back(IDLE(1, 1, 8'h23, 32'hAA));
    tbl.push_back(IDLE(1, 0, 0, 0));
    // Dispatch bypass: both ports match, port 1 wins; then port 2 alone
    tbl.push_back(V(0, 1, 8'h30, 0, 0, 0, 3, 0, 1, 3, 32'h11, 1, 3, 32'h99, 1, 0, 0, 0, 0));
    tbl.push_back(IDLE(1, 1, 8'h30, 32'h11));
    tbl.push_back(V(0, 1, 8'h31, 0, 0, 0, 7, 0, 0, 0, 0, 1, 7, 32'h42, 1, 0, 0, 0, 0));
    tbl.push_back(IDLE(1, 1, 8'h31, 32'h42));
    // Flush with three busy entries plus a same-cycle dispatch
    tbl.push_back(V(0, 2, 8'h50, 8'h51, 1, 1, 0, 32'h05, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 1, 8'h52, 0, 1, 0, 0, 32'h05, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h50, 32'h05));
    tbl.push_back(V(1, 1, 8'h53, 0, 1, 0, 0, 32'h05, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h50, 32'h05));
    tbl.push_back(IDLE(0, 0, 0, 0));
    // All four entries are free again after the flush
    tbl.push_back(V(0, 2, 8'h60, 8'h61, 1, 1, 0, 32'h06, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(V(0, 2, 8'h62, 8'h63, 1, 1, 0, 32'h06, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h60, 32'h06));
    tbl.push_back(V(0, 1, 8'h64, 0, 1, 0, 0, 32'h06, 0, 0, 0, 0, 0, 0, 0, 1, 1, 8'h60, 32'h06));
    tbl.push_back(IDLE(1, 1, 8'h60, 32'h06));
    tbl.push_back(IDLE(1, 1, 8'h61, 32'h06));
    tbl.push_back(IDLE(1, 1, 8'h62, 32'h06));
    tbl.push_back(IDLE(1, 1, 8'h63, 32'h06));
    tbl.push_back(IDLE(1, 0, 0, 0));
    // Wakeup through CDB port 2 only
    tbl.push_back(V(0, 2, 8'h70, 8'h71, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h5A, 1, 0, 0, 0, 0));
    tbl.push_back(IDLE(1, 1, 8'h70, 32'h5A));
    tbl.push_back(IDLE(1, 1, 8'h71, 32'h5A));
    tbl.push_back(IDLE(1, 0, 0, 0));

    drive(IDLE(0, 0, 0, 0));
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_dp_num = 2'd2;
    chk("reset issue_vld", 32'(o_issue_vld), 32'd0);
    chk("reset stall", 32'(o_stall), 32'd0);
    i_dp_num = 2'd0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // Hold: one ready entry presented with i_issue_rdy low, others waiting on tag 12
    step(V(0, 2, 8'h40, 8'h41, 1, 0, 12, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "hold0");
    step(V(0, 2, 8'h42, 8'h43, 0, 0, 12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h40, 32'h44), "hold1");
    for (int k = 0; k < 5; k++)
      step(V(0, 1, 8'h45, 0, 1, 0, 0, 32'h55, 0, 0, 0, 0, 0, 0, 0, 1, 1, 8'h40, 32'h44),
           $sformatf("hold_wait%0d", k));
    step(V(0, 1, 8'h45, 0, 1, 0, 0, 32'h55, 0, 0, 0, 0, 0, 0, 1, 1, 1, 8'h40, 32'h44), "hold_fire");
    step(V(0, 1, 8'h46, 0, 1, 0, 0, 32'h66, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "hold_reuse");
    step(IDLE(0, 1, 8'h46, 32'h66), "hold_reissue");
    step(V(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'h46, 32'h66), "hold_flush");
    step(IDLE(0, 0, 0, 0), "hold_empty");

    // Async reset pulse between clock edges with two ready entries
    step(V(0, 2, 8'h80, 8'h81, 1, 1, 0, 32'h88, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rst_fill");
    step(IDLE(0, 1, 8'h80, 32'h88), "rst_pre");
    #3;
    i_rst_n = 1'b0;
    #1;
    chk("rst_async issue_vld", 32'(o_issue_vld), 32'd0);
    chk("rst_async stall", 32'(o_stall), 32'd0);
    #3;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    for (int k = 0; k < 3; k++) step(IDLE(1, 0, 0, 0), $sformatf("rst_after%0d", k));
    step(V(0, 1, 8'h90, 0, 1, 0, 0, 32'h99, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "rst_redisp");
    step(IDLE(1, 1, 8'h90, 32'h99), "rst_issue");
    step(IDLE(1, 0, 0, 0), "rst_done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
